pio_txfifo_wb: RTL and testbench
================================

Name: pio_txfifo_wb

Overview:
- Wishbone-slave TX FIFO that sits directly upstream of wb_pio's state-machine pull port.
- The management SoC pushes 32-bit words over Wishbone; the PIO state machine consumes them through a valid/ready pull stream.
- Provides status, a sticky overflow flag and a low-water interrupt so firmware can refill without polling.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- BASE_ADR, 32'h3000_0000, Wishbone base address; bits [31:4] are compared.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- pull_valid_o  out  1  FIFO head is valid.
- pull_data_o  out  32  FIFO head word.
- pull_ready_i  in  1  PIO consumes the head this cycle.
- irq_o  out  1  low-water interrupt, level-sensitive.

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, pull_valid_o=0, pull_data_o=0, irq_o=1 (level 0 <= reset threshold 0). Also level=0, pointers=0, overflow=0, thresh=0.
- Bus request (req) = cyc & stb & !wbs_ack_o.
- Hit = req & (adr[31:4]==BASE_ADR[31:4]).
- Ack: wbs_ack_o=1 exactly one cycle after req, for one cycle. Every req is acked, hit or miss.
- Miss reads return 0; miss writes have no effect.
- Register map (adr[3:2]), side effects commit in the req cycle:
  - 0 TXF, W: push wbs_dat_i and ignore sel. Reads return 0.
  - 1 STATUS, R: [4:0]=level, [8]=empty, [9]=full, [10]=overflow. Writes ignored.
  - 2 THRESH, RW: [4:0]. A write updates only if sel[0]=1.
  - 3 CTRL, W: bit0=1 clears overflow; bit1=1 flushes the FIFO (level=0, pointers=0). Reads return 0.
- wbs_dat_o is registered with ack and is valid only while ack=1; it is 0 otherwise.
- FIFO: circular buffer with wrapping pointers; level counter 0..DEPTH; full = level==DEPTH; empty = level==0.
- pull_valid_o = !empty. pull_data_o = mem[rd_ptr], a registered array read with no bubble after a pop.
- Pop when pull_valid_o & pull_ready_i. pull_ready_i while empty has no effect.
- Push while full with no pop in the same cycle: data dropped, overflow set (sticky), bus still acked.
- Push and pop in the same cycle:
  - When full: push accepted, level unchanged.
  - When empty: the pop is not possible (valid=0); the push lands and valid rises the next cycle.
- Flush and a same-cycle pop: flush wins and the pop is discarded.
- Flush and a same-cycle push: impossible, since only one bus op occurs per cycle.
- First-word latency: push in cycle N, pull_valid_o=1 in N+1.
- irq_o is registered: irq_o = (level <= thresh), evaluated on next-state level. Writing THRESH >= DEPTH forces irq_o high.
- Reset mid-transfer: the bus op is abandoned with no ack the next cycle, the FIFO is emptied, overflow is cleared and thresh=0.
- Back-to-back Wishbone ops sustain one op per 2 cycles, because the ack gap is enforced by req.

Test Plan:
- Reset, then read STATUS: ack 1 cycle after stb, dat=0x100 (empty, level 0); irq_o=1, pull_valid_o=0.
- With pull_ready_i=0, write 0xA1,0xA2,0xA3,0xA4 to TXF (DEPTH=4): STATUS=0x204; then write 0xA5: acked, STATUS=0x604; pull_data_o still 0xA1.
- Raise pull_ready_i for 4 cycles: pull_data_o sequence 0xA1,0xA2,0xA3,0xA4 on consecutive cycles, then pull_valid_o=0. Write CTRL=1: overflow clears, STATUS=0x100.
- THRESH=1, push 3 words: irq_o drops the cycle after level reaches 2. Pop 1 word: irq_o stays 0 (level 2). Pop another: irq_o=1 (level 1).
- Fill the FIFO, hold pull_ready_i=1 and push 0xB0 in the same cycle as a pop: no overflow, level stays 4, 0xB0 is popped last.
- Write to BASE_ADR+0x10 (miss): acked, no state change. Assert wb_rst_i mid-FIFO with level 3: next cycle level 0, pull_valid_o=0, ack=0.

Source files
------------

// File: rtl/pio_txfifo_wb.sv
// Wishbone-slave TX FIFO feeding the PIO state-machine pull port.
// Firmware pushes words over the bus; the PIO drains them through a valid/ready stream.
module pio_txfifo_wb #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        pull_valid_o,
  output logic [31:0] pull_data_o,
  input  logic        pull_ready_i,
  output logic        irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  typedef enum logic [1:0] {
    REG_TXF    = 2'd0,
    REG_STATUS = 2'd1,
    REG_THRESH = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [4:0]    level, level_nxt, thresh, thresh_nxt;
  logic          overflow, overflow_nxt;

  logic        req, hit, wr_hit, rd_hit;
  reg_e        sel_reg;
  logic        empty, full;
  logic        push_req, push, pop, flush, clr_ovf;
  logic [31:0] rdata, head_nxt, pull_data_nxt;

  assign empty        = (level == 5'd0);
  assign full         = (level == DEPTH_L);
  assign pull_valid_o = !empty;

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    req      = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    hit      = req && (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    sel_reg  = reg_e'(wbs_adr_i[3:2]);
    wr_hit   = hit && wbs_we_i;
    rd_hit   = hit && !wbs_we_i;

    push_req = wr_hit && (sel_reg == REG_TXF);
    flush    = wr_hit && (sel_reg == REG_CTRL) && wbs_dat_i[1];
    clr_ovf  = wr_hit && (sel_reg == REG_CTRL) && wbs_dat_i[0];
    // Flush wins over a same-cycle pop; a full FIFO still accepts a push if a pop frees a slot.
    pop      = pull_valid_o && pull_ready_i && !flush;
    push     = push_req && (!full || pop);

    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    level_nxt    = level;
    thresh_nxt   = thresh;
    overflow_nxt = overflow;

    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      level_nxt  = 5'd0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + AW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + AW'(1);
      level_nxt = level + {4'b0, push} - {4'b0, pop};
    end

    if (push_req && full && !pop) overflow_nxt = 1'b1;
    else if (clr_ovf)             overflow_nxt = 1'b0;

    if (wr_hit && (sel_reg == REG_THRESH) && wbs_sel_i[0]) thresh_nxt = wbs_dat_i[4:0];

    // A word pushed into the slot that becomes the head bypasses the array read.
    head_nxt      = (push && (wr_ptr == rd_ptr_nxt)) ? wbs_dat_i : mem[rd_ptr_nxt];
    pull_data_nxt = (level_nxt == 5'd0) ? 32'd0 : head_nxt;

    rdata = 32'd0;
    case (sel_reg)
      REG_STATUS: rdata = {21'd0, overflow, full, empty, 3'd0, level};
      REG_THRESH: rdata = {27'd0, thresh};
      default:    rdata = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= 32'd0;
      pull_data_o <= 32'd0;
      irq_o       <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= 5'd0;
      thresh      <= 5'd0;
      overflow    <= 1'b0;
    end else begin
      wbs_ack_o   <= req;
      wbs_dat_o   <= rd_hit ? rdata : 32'd0;
      pull_data_o <= pull_data_nxt;
      irq_o       <= (level_nxt <= thresh_nxt);
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      level       <= level_nxt;
      thresh      <= thresh_nxt;
      overflow    <= overflow_nxt;
    end
  end

  // NOTE: the storage array is not reset; level and pointers alone decide which entries are live.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= wbs_dat_i;
  end

endmodule

// File: tb/tb_pio_txfifo_wb.sv
// Directed self-checking bench for pio_txfifo_wb (DEPTH=4).
module tb_pio_txfifo_wb;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_TXF = BASE + 32'h0;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_TH  = BASE + 32'h8;
  localparam logic [31:0] A_CT  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        pv;
  logic [31:0] pd;
  logic        pr;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  pio_txfifo_wb #(.DEPTH(4), .BASE_ADR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .pull_valid_o(pv), .pull_data_o(pd), .pull_ready_i(pr), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Wishbone op: request for one cycle, ack checked on the next, idle cycle after.
  task automatic wb_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    check("ack_low_in_req", {31'd0, ack}, 32'd0);
    tick();
    check("ack_after_req", {31'd0, ack}, 32'd1);
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_op(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic pop_n(input int n);
    pr = 1'b1;
    for (int i = 0; i < n; i++) tick();
    pr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0; pr = 0;
    tick(); tick();
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_valid", {31'd0, pv}, 32'd0);
    check("rst_pdata", pd, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd1);
    rst = 1'b0;
    tick();

    wb_op(1'b0, A_ST, 32'd0, 4'hF, rd);
    check("status_reset", rd, 32'h100);
    check("dat_zero_after_ack", rdat, 32'd0);

    // Fill, then overflow.
    for (int i = 0; i < 4; i++) wr(A_TXF, 32'hA1 + 32'(i));
    wb_op(1'b0, A_ST, 32'd0, 4'hF, rd);
    check("status_full", rd, 32'h204);
    wr(A_TXF, 32'hA5);
    wb_op(1'b0, A_ST, 32'd0, 4'hF, rd);
    check("status_ovf", rd, 32'h604);
    check("head_after_ovf", pd, 32'hA1);

    // Drain on consecutive cycles.
    pr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'd0, pv}, 32'd1);
      check("drain_data", pd, 32'hA1 + 32'(i));
      tick();
    end
    pr = 1'b0;
    check("drained_valid", {31'd0, pv}, 32'd0);
    wr(A_CT, 32'h1);
    wb_op(1'b0, A_ST, 32'd0, 4'hF, rd);
    check("status_ovf_clr", rd, 32'h100);

    // Threshold and low-water interrupt.
    wr(A_TH, 32'h1);
    wb_op(1'b1, A_TH, 32'h7, 4'hE, rd);
    wb_op(1'b0, A_TH, 32'd0, 4'hF, rd);
    check("thresh_rb", rd, 32'h1);
    wr(A_TXF, 32'hC1);
    check("irq_lvl1", {31'd0, irq}, 32'd1);
    wr(A_TXF, 32'hC2);
    check("irq_lvl2", {31'd0, irq}, 32'd0);
    wr(A_TXF, 32'hC3);
    check("irq_lvl3", {31'd0, irq}, 32'd0);
    pop_n(1);
    check("irq_pop_lvl2", {31'd0, irq}, 32'd0);
    check("head_c2", pd, 32'hC2);
    pop_n(1);
    check("irq_pop_lvl1", {31'd0, irq}, 32'd1);
    check("head_c3", pd, 32'hC3);
    wr(A_CT, 32'h2);
    wb_op(1'b0, A_ST, 32'd0, 4'hF, rd);
    check("status_flush", rd, 32'h100);
    check("valid_flush", {31'd0, pv}, 32'd0);

    // Push into a full FIFO while it pops.
    for (int i = 0; i < 4; i++) wr(A_TXF, 32'hD0 + 32'(i));
    pr = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_TXF; wdat = 32'hB0; sel = 4'hF;
    tick();
    pr = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("pushpop_ack", {31'd0, ack}, 32'd1);
    check("pushpop_head", pd, 32'hD1);
    tick();
    wb_op(1'b0, A_ST, 32'd0, 4'hF, rd);
    check("status_pushpop", rd, 32'h204);
    pr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pushpop_order", pd, (i == 3) ? 32'hB0 : 32'hD1 + 32'(i));
      tick();
    end
    pr = 1'b0;
    check("pushpop_empty", {31'd0, pv}, 32'd0);

    // Address miss: acked, no effect, reads zero.
    for (int i = 0; i < 3; i++) wr(A_TXF, 32'hE1 + 32'(i));
    wr(BASE + 32'h10, 32'hEE);
    wb_op(1'b0, BASE + 32'h14, 32'd0, 4'hF, rd);
    check("miss_read", rd, 32'd0);
    wb_op(1'b0, A_ST, 32'd0, 4'hF, rd);
    check("status_miss", rd, 32'h003);
    check("head_miss", pd, 32'hE1);

    // Reset mid-transfer with level 3.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_ST; rst = 1'b1;
    tick();
    check("rst_mid_ack", {31'd0, ack}, 32'd0);
    check("rst_mid_valid", {31'd0, pv}, 32'd0);
    check("rst_mid_irq", {31'd0, irq}, 32'd1);
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    tick();
    wb_op(1'b0, A_ST, 32'd0, 4'hF, rd);
    check("status_after_rst", rd, 32'h100);
    wb_op(1'b0, A_TH, 32'd0, 4'hF, rd);
    check("thresh_after_rst", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
